spmv_mul_pipe: RTL and testbench

Parametrised pipelined integer multiplier with valid tracking, the next generation of the fixed two-register signed multiplier used in the Serpens SpMV datapath. Operand widths, per-operand signedness, pipeline depth, post-multiply right shift and output width are generics. A valid bit travels alongside the data, and the result can be truncated or saturated to the output width. It sits between the Y-arbiter index/scale logic and the accumulation stage, wherever a scaled product with a known, stallable latency is needed.

---
 rtl/spmv_mul_pkg.sv | 30 +++
 rtl/spmv_mul_delay.sv | 26 ++
 rtl/spmv_mul_pipe.sv | 69 ++++++
 tb/tb_spmv_mul_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spmv_mul_pkg.sv
// spmv_mul_pkg: shared constants and extend/narrow helpers for spmv_mul_pipe; saturates when SPMV_MUL_SAT_EN is defined
package spmv_mul_pkg;
    localparam int MAX_STAGE = 8;
    localparam int PW = 128;
    typedef logic signed [PW-1:0] wide_t;
    typedef struct packed {
        logic  ovf;
        wide_t val;
    } narrow_t;
    localparam wide_t ONE = 1;
    function automatic wide_t sext(input wide_t x, input int w);
        return (x <<< (PW - w)) >>> (PW - w);
    endfunction
    function automatic wide_t zext(input wide_t x, input int w);
        return x & ((ONE <<< w) - ONE);
    endfunction
    function automatic narrow_t narrow(input wide_t s, input int width, input logic signed_mode);
        narrow_t r;
        wide_t hi, lo;
        hi = signed_mode ? (ONE <<< (width - 1)) - ONE : (ONE <<< width) - ONE;
        lo = signed_mode ? -(ONE <<< (width - 1)) : ONE - ONE;
        r.ovf = (s > hi) || (s < lo);
`ifdef SPMV_MUL_SAT_EN
        r.val = r.ovf ? ((s < lo) ? lo : hi) : s;
`else
        r.val = s;
`endif
        return r;
    endfunction
endpackage

// File: rtl/spmv_mul_delay.sv
// spmv_mul_delay: ce-qualified register chain with synchronous reset; DEPTH=0 is a wire
module spmv_mul_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_reg
        logic [WIDTH-1:0] r [DEPTH];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) r[i] <= '0;
            end else if (ce) begin
                r[0] <= din;
                for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
            end
        end
        assign dout = r[DEPTH-1];
    end
endmodule

// File: rtl/spmv_mul_pipe.sv
// spmv_mul_pipe: pipelined multiplier with valid tracking and shift/narrow; define SPMV_MUL_SAT_EN to saturate instead of wrap
module spmv_mul_pipe
    import spmv_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 27,
    parameter int din1_WIDTH = 30,
    parameter int dout_WIDTH = 30,
    parameter int SIGNED0    = 1,
    parameter int SIGNED1    = 1,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  vld_in,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  vld_out,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int TAIL = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    wide_t a_x, b_x, s_full;
    narrow_t nr;
    logic [dout_WIDTH:0] res_q;
    // with one stage the result register sees the live operands directly
    if (NUM_STAGE == 1) begin : g_comb
        assign a_q = din0;
        assign b_q = din1;
    end else begin : g_opreg
        always_ff @(posedge clk) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else if (ce) begin
                a_q <= din0;
                b_q <= din1;
            end
        end
    end
    always_comb begin
        a_x = (SIGNED0 != 0) ? sext(wide_t'(a_q), din0_WIDTH) : zext(wide_t'(a_q), din0_WIDTH);
        b_x = (SIGNED1 != 0) ? sext(wide_t'(b_q), din1_WIDTH) : zext(wide_t'(b_q), din1_WIDTH);
        s_full = (a_x * b_x) >>> SHIFT;
        nr = narrow(s_full, dout_WIDTH, (SIGNED0 != 0) || (SIGNED1 != 0));
    end
    always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else if (ce) res_q <= {nr.ovf, nr.val[dout_WIDTH-1:0]};
    end
    spmv_mul_delay #(.WIDTH(dout_WIDTH + 1), .DEPTH(TAIL)) u_tail (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   (res_q),
        .dout  ({ovf, dout})
    );
    spmv_mul_delay #(.WIDTH(1), .DEPTH(NUM_STAGE)) u_vld (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   (vld_in),
        .dout  (vld_out)
    );
endmodule

// File: tb/tb_spmv_mul_pipe.sv
// tb_spmv_mul_pipe: three configurations share one stimulus stream; a scoreboard checks value, ovf and latency
module tb_spmv_mul_pipe;
    typedef struct {
        int          t;
        logic [29:0] d;
        logic        o;
    } exp_t;

    localparam int NS [3] = '{4, 2, 1};
    localparam int W0 [3] = '{27, 27, 4};
    localparam int S0 [3] = '{1, 1, 0};
    localparam int SH [3] = '{0, 0, 1};
    localparam int WO [3] = '{30, 8, 30};

    logic clk = 0, reset = 1, ce = 0, vld = 0;
    logic [26:0] a0 = '0;
    logic [29:0] b0 = '0;
    logic vo0, vo1, vo2, ov0, ov1, ov2;
    logic [29:0] dd0, dd2;
    logic [7:0] dd1;

    exp_t q [3][$];
    int cnt = 0, n_chk = 0, n_fail = 0;
    logic last_rst = 0, last_ce = 0;
    logic pv [3];
    logic po [3];
    logic [29:0] pd [3];

    always #5 clk = ~clk;

    spmv_mul_pipe #(.NUM_STAGE(4)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vld), .din0(a0), .din1(b0),
        .vld_out(vo0), .dout(dd0), .ovf(ov0));
    spmv_mul_pipe #(.dout_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vld), .din0(a0), .din1(b0),
        .vld_out(vo1), .dout(dd1), .ovf(ov1));
    spmv_mul_pipe #(.NUM_STAGE(1), .din0_WIDTH(4), .SIGNED0(0), .SHIFT(1)) dut2 (
        .clk(clk), .reset(reset), .ce(ce), .vld_in(vld), .din0(a0[3:0]), .din1(b0),
        .vld_out(vo2), .dout(dd2), .ovf(ov2));

    function automatic longint ext(longint x, int w, bit s);
        longint m = (64'sd1 <<< w) - 1;
        longint v = x & m;
        return (s && v[w-1]) ? v - (64'sd1 <<< w) : v;
    endfunction

    // reference: exact product, floor shift, range test against the output width
    function automatic exp_t model(int k, logic [26:0] a, logic [29:0] b);
        exp_t e;
        longint p, s, hi, lo, v;
        bit sm = (S0[k] != 0);
        sm = 1'b1;
        p = ext(longint'(a), W0[k], S0[k] != 0) * ext(longint'(b), 30, 1'b1);
        s = p >>> SH[k];
        hi = sm ? (64'sd1 <<< (WO[k] - 1)) - 1 : (64'sd1 <<< WO[k]) - 1;
        lo = sm ? -(64'sd1 <<< (WO[k] - 1)) : 64'sd0;
        e.o = (s > hi) || (s < lo);
`ifdef SPMV_MUL_SAT_EN
        v = e.o ? ((s < lo) ? lo : hi) : s;
`else
        v = s;
`endif
        e.d = 30'(v & ((64'sd1 <<< WO[k]) - 1));
        e.t = cnt;
        return e;
    endfunction

    task automatic chk(input bit ok, input string name, input int k, input longint got, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, k, $time, got, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [29:0] d, input logic o);
        exp_t e;
        if (last_rst) begin
            chk(!v && d == 0 && !o, "reset", k, {v, o, d}, 0);
        end else if (!last_ce) begin
            chk(v == pv[k] && d == pd[k] && o == po[k], "hold", k, {v, o, d}, {pv[k], po[k], pd[k]});
        end else if (v) begin
            if (q[k].size() == 0) begin
                chk(1'b0, "spurious", k, {v, o, d}, 0);
            end else begin
                e = q[k].pop_front();
                chk(d == e.d && o == e.o, "data", k, {o, d}, {e.o, e.d});
                chk(cnt == e.t + NS[k], "latency", k, cnt, e.t + NS[k]);
            end
        end else if (q[k].size() != 0 && q[k][0].t + NS[k] == cnt) begin
            chk(1'b0, "missing", k, 0, 1);
        end
        pv[k] = v;
        pd[k] = d;
        po[k] = o;
    endtask

    always @(posedge clk) begin
        last_rst = reset;
        last_ce = ce;
        if (reset) begin
            for (int k = 0; k < 3; k++) q[k].delete();
        end else if (ce) begin
            if (vld) for (int k = 0; k < 3; k++) q[k].push_back(model(k, a0, b0));
            cnt++;
        end
    end

    always @(negedge clk) begin
        mon(0, vo0, dd0, ov0);
        mon(1, vo1, {22'b0, dd1}, ov1);
        mon(2, vo2, dd2, ov2);
    end

    task automatic cyc(input bit v, input bit c, input logic [26:0] a, input logic [29:0] b);
        vld = v;
        ce = c;
        a0 = a;
        b0 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, '0, '0);
    endtask

    initial begin
        int r, sa, sb;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        cyc(1'b1, 1'b1, 27'(-3), 30'(5));
        idle(5);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 27'(i), 30'(i + 1));
        idle(5);
        cyc(1'b1, 1'b1, 27'(20), 30'(10));
        cyc(1'b1, 1'b1, 27'(15), 30'(-2));
        idle(5);
        cyc(1'b1, 1'b1, 27'(7), 30'(9));
        cyc(1'b0, 1'b1, '0, '0);
        repeat (3) cyc(1'b1, 1'b0, 27'(123), 30'(456));
        idle(6);
        cyc(1'b1, 1'b1, 27'(11), 30'(13));
        cyc(1'b1, 1'b1, 27'(17), 30'(19));
        reset = 1;
        cyc(1'b1, 1'b1, 27'(5), 30'(5));
        reset = 0;
        idle(8);
        repeat (400) begin
            r = int'($urandom_range(0, 3));
            sa = int'($urandom_range(0, 40)) - 20;
            sb = int'($urandom_range(0, 40)) - 20;
            reset = ($urandom_range(0, 99) == 0);
            case (r)
                0: cyc(1'b1, $urandom_range(0, 9) < 7, 27'(sa), 30'(sb));
                1: cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, 27'($urandom), 30'($urandom));
                2: cyc(1'b1, 1'b1, {sa[0], {26{~sa[0]}}}, {sb[0], {29{~sb[0]}}});
                default: cyc($urandom_range(0, 1) == 1, 1'b1, 27'($urandom_range(0, 300)), 30'($urandom_range(0, 300)));
            endcase
        end
        reset = 0;
        idle(10);
        for (int k = 0; k < 3; k++) chk(q[k].size() == 0, "drain", k, q[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
